dcache_meta_altram: RTL and testbench
=====================================

DCACHE_META_ALTRAM -- requirements
Module: dcache_meta_altram

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 1, bits per metadata entry (valid/dirty/LRU/tag slice).
REQ-002 SHALL expose parameter INDEX_BITS, default 8, address width; NUM_ENTRIES = 2**INDEX_BITS.
REQ-003 SHALL expose port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL expose port aclr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL expose port flush  input  1  single-cycle request to zero the whole array.
REQ-006 SHALL expose port busy  output  1  high while a clear sweep is in progress.
REQ-007 SHALL expose port rden  input  1  read enable.
REQ-008 SHALL expose port rdaddress  input  INDEX_BITS  read index.
REQ-009 SHALL expose port q  output  DATA_WIDTH  read data.
REQ-010 SHALL expose port wren  input  1  write enable.
REQ-011 SHALL expose port wraddress  input  INDEX_BITS  write index.
REQ-012 SHALL expose port wmask  input  DATA_WIDTH  per-bit write enable; 1 = bit written.
REQ-013 SHALL expose port data  input  DATA_WIDTH  write data.

Function
REQ-014 SHALL store NUM_ENTRIES x DATA_WIDTH bits in an inferred simple dual-port block RAM (one read port, one write port); no register-file implementation of the array.
REQ-015 SHALL, with busy=0, perform a write on an edge with wren=1: mem[wraddress] bits where wmask=1 take data; bits where wmask=0 are unchanged.
REQ-016 SHALL, with busy=0, return mem[rdaddress] on q in the cycle after an edge with rden=1 (latency 1).
REQ-017 SHALL hold q at its last value while rden=0; a later write to the held address does not change q.
REQ-018 SHALL, on a same-edge read and write to the same address, return the post-write value: q = (old & ~wmask) | (data & wmask), never the pre-write value.
REQ-019 SHALL keep the REQ-018 merged value on q in later rden=0 cycles, and also in later rden=1 cycles to the same address with no new write.
REQ-020 SHALL implement a two-state FSM: IDLE (busy=0) and SWEEP (busy=1) with a sweep counter of INDEX_BITS bits.
REQ-021 SHALL transition IDLE->SWEEP on an edge with flush=1 and set counter to 0.
REQ-022 SHALL, in SWEEP, write all-zero to mem[counter] each edge and increment counter.
REQ-023 SHALL transition SWEEP->IDLE on the edge that clears entry NUM_ENTRIES-1; busy is high for exactly NUM_ENTRIES cycles per sweep.
REQ-024 SHALL ignore flush while busy=1; the sweep is not restarted or extended.
REQ-025 SHALL ignore wren while busy=1; the array is not modified by the requestor.
REQ-026 SHALL treat rden=1 while busy=1 as a read returning all-zero on q next cycle.
REQ-027 SHALL perform a requestor write on the same edge that flush is sampled in IDLE; the sweep then zeroes that entry.
REQ-028 SHALL drive busy directly from the FSM state register, with no combinational path from inputs.

Reset
REQ-029 SHALL, while aclr=1, asynchronously force state=SWEEP, counter=0, q=0, and clear all bypass/pipeline registers.
REQ-030 SHALL, after aclr deasserts, run a full sweep: busy stays 1 for NUM_ENTRIES edges, then 0; the array is all-zero on exit.
REQ-031 SHALL restart the sweep from counter 0 when aclr asserts mid-sweep.
REQ-032 SHALL not depend on RAM initial contents; after the sweep, every read returns 0 until written.

Verification (DATA_WIDTH=8, INDEX_BITS=4)
REQ-033 SHALL cover: release aclr -> busy=1 for 16 cycles then 0; read of every index returns 8'h00.
REQ-034 SHALL cover: write idx 3 = 8'hA5, mask 8'hFF; then write idx 3 = 8'h0F, mask 8'h0F; next-cycle read idx 3 -> q=8'hAF.
REQ-035 SHALL cover: mem[5]=8'hF0; same edge rden idx 5 and wren idx 5, data 8'h0C, mask 8'h0F -> q=8'hFC next cycle, held 3 more cycles with rden=0.
REQ-036 SHALL cover: fill all 16 entries with 8'hFF; pulse flush -> busy 16 cycles; flush pulse and wren at cycle 8 ignored; all reads -> 8'h00.
REQ-037 SHALL cover: aclr asserted at sweep cycle 7 -> q=0 immediately; after release busy=1 for a full 16 cycles.
REQ-038 SHALL cover: read idx 2 (8'h11) with rden then write idx 2 = 8'h22 with rden=0 -> q stays 8'h11 until next read.

Source files
------------

// File: rtl/dcache_meta_altram.sv
`default_nettype none
// ============================================================================
// Module      : dcache_meta_altram
// Description : Data-cache metadata array (valid/dirty/LRU/tag slices) held
//               in a simple dual-port block RAM. It supports per-bit masked
//               writes. A same-address read and write on one edge returns the
//               post-write value. A flush, or reset, starts a hardware sweep
//               that zeroes every entry. While the sweep runs, busy is high,
//               requestor writes are dropped and reads return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_meta_altram #(
  parameter int DATA_WIDTH = 1,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  flush,
  output logic                  busy,
  input  logic                  rden,
  input  logic [INDEX_BITS-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q,
  input  logic                  wren,
  input  logic [INDEX_BITS-1:0] wraddress,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0] data
);

  localparam int                  c_num_entries = 2 ** INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] c_last_index = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [INDEX_BITS-1:0] r_count;
  logic [INDEX_BITS-1:0] w_count_next;

  // RAM write-port controls. The sweep takes the write port over from the requestor.
  logic                  w_ram_we;
  logic [INDEX_BITS-1:0] w_ram_waddr;
  logic [DATA_WIDTH-1:0] w_ram_wmask;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  // Block RAM storage and its raw synchronous read register. Neither is reset.
  logic [DATA_WIDTH-1:0] r_mem [0:c_num_entries-1];
  logic [DATA_WIDTH-1:0] r_ram_q;

  // Read-side bookkeeping, all asynchronously cleared.
  logic                  r_rd_valid;   // a read was issued on the previous edge
  logic                  r_rd_zero;    // that read happened during a sweep
  logic                  r_fwd_en;     // that read collided with an accepted write
  logic [DATA_WIDTH-1:0] r_fwd_mask;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [DATA_WIDTH-1:0] r_q_hold;     // q value presented while no new read arrives
  logic [DATA_WIDTH-1:0] w_q_new;

  // Sweep FSM state and counter. Reset enters the sweep at entry 0.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state <= ST_SWEEP;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Sweep FSM next state. Flush is only honoured in IDLE, so a sweep is never extended.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          w_state_next = ST_SWEEP;
          w_count_next = '0;
        end
      end
      ST_SWEEP: begin
        w_count_next = r_count + 1'b1;
        if (r_count == c_last_index) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_SWEEP;
        w_count_next = '0;
      end
    endcase
  end

  assign busy = (r_state == ST_SWEEP);

  // Write-port arbitration: the sweep zeroes one entry per edge, otherwise the requestor writes.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = wraddress;
    w_ram_wmask = wmask;
    w_ram_wdata = data;
    if (busy) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_count;
      w_ram_wmask = '1;
      w_ram_wdata = '0;
    end else if (wren) begin
      w_ram_we    = 1'b1;
    end
  end

  // RAM write port with per-bit write enables.
  always_ff @(posedge clock) begin
    if (w_ram_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (w_ram_wmask[i]) begin
          r_mem[w_ram_waddr][i] <= w_ram_wdata[i];
        end
      end
    end
  end

  // RAM read port. On a same-address collision the RAM returns the old entry.
  always_ff @(posedge clock) begin
    if (rden) begin
      r_ram_q <= r_mem[rdaddress];
    end
  end

  // Capture the read context so the merged, zeroed or held value can be formed next cycle.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b0;
      r_fwd_en   <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
      r_q_hold   <= '0;
    end else begin
      r_rd_valid <= rden;
      r_rd_zero  <= rden & busy;
      r_fwd_en   <= rden & ~busy & wren & (rdaddress == wraddress);
      if (rden) begin
        r_fwd_mask <= wmask;
        r_fwd_data <= data;
      end
      if (r_rd_valid) begin
        r_q_hold <= w_q_new;
      end
    end
  end

  // Fresh read result: zero during a sweep, or the old entry merged with the colliding write.
  always_comb begin
    w_q_new = r_ram_q;
    if (r_rd_zero) begin
      w_q_new = '0;
    end else if (r_fwd_en) begin
      w_q_new = (r_ram_q & ~r_fwd_mask) | (r_fwd_data & r_fwd_mask);
    end
  end

  assign q = r_rd_valid ? w_q_new : r_q_hold;

endmodule
`default_nettype wire

// File: tb/tb_dcache_meta_altram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_meta_altram
// Description : Scoreboard bench for dcache_meta_altram (8-bit x 16 entries).
//               Directed scenarios are followed by random traffic. Each is
//               checked against an abstract array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_meta_altram;

  localparam int DW = 8;
  localparam int IB = 4;
  localparam int NE = 16;

  logic          clock     = 1'b0;
  logic          aclr      = 1'b0;
  logic          flush     = 1'b0;
  logic          busy;
  logic          rden      = 1'b0;
  logic [IB-1:0] rdaddress = '0;
  logic [DW-1:0] q;
  logic          wren      = 1'b0;
  logic [IB-1:0] wraddress = '0;
  logic [DW-1:0] wmask     = '0;
  logic [DW-1:0] data      = '0;

  always #5 clock = ~clock;

  dcache_meta_altram #(.DATA_WIDTH(DW), .INDEX_BITS(IB)) dut (
    .clock     (clock),
    .aclr      (aclr),
    .flush     (flush),
    .busy      (busy),
    .rden      (rden),
    .rdaddress (rdaddress),
    .q         (q),
    .wren      (wren),
    .wraddress (wraddress),
    .wmask     (wmask),
    .data      (data)
  );

  typedef struct {
    logic          busy;
    logic [DW-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the array contents, the cycles of sweep left and the visible q.
  logic [DW-1:0] m_mem [NE];
  int            m_busy_left = 0;
  logic [DW-1:0] m_q = '0;

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_mem[i] = '0;
    m_busy_left = NE;
    m_q         = '0;
  endtask

  // One clock edge of the abstract model. A flush clears the whole array at
  // once. This matches what a requestor can observe, because writes are
  // dropped and reads return zero for the following NE cycles.
  task automatic model_edge(input logic re, input logic [IB-1:0] ra, input logic we,
                            input logic [IB-1:0] wa, input logic [DW-1:0] wm,
                            input logic [DW-1:0] wd, input logic fl);
    if (aclr) begin
      model_reset();
    end else if (m_busy_left > 0) begin
      if (re) m_q = '0;
      m_busy_left--;
    end else begin
      if (we) m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
      if (re) m_q = m_mem[ra];
      if (fl) begin
        for (int i = 0; i < NE; i++) m_mem[i] = '0;
        m_busy_left = NE;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.busy = (m_busy_left > 0);
    e.q    = m_q;
    sb.push_back(e);
  endtask

  // Apply one cycle of stimulus (inputs change on the falling edge).
  task automatic step(input logic re, input logic [IB-1:0] ra, input logic we,
                      input logic [IB-1:0] wa, input logic [DW-1:0] wm,
                      input logic [DW-1:0] wd, input logic fl);
    rden = re; rdaddress = ra; wren = we; wraddress = wa; wmask = wm; data = wd; flush = fl;
    @(posedge clock);
    model_edge(re, ra, we, wa, wm, wd, fl);
    push_exp();
    @(negedge clock);
    rden = 1'b0; wren = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [IB-1:0] a);
    step(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [IB-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    step(1'b0, '0, 1'b1, a, m, d, 1'b0);
  endtask

  // Assert reset between edges. It must take effect before the next rising edge.
  task automatic async_reset(input int hold_cycles);
    @(posedge clock);
    #2 aclr = 1'b1;
    model_reset();
    push_exp();
    @(negedge clock);
    idle(hold_cycles);
    aclr = 1'b0;
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (busy !== e.busy) begin
          n_err++;
          $display("FAIL busy @%0t: got %b expected %b", $time, busy, e.busy);
        end
        n_vec++;
        if (q !== e.q) begin
          n_err++;
          $display("FAIL q @%0t: got %h expected %h", $time, q, e.q);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Power-up reset, then the full sweep and a readback of every entry.
    #2 aclr = 1'b1;
    model_reset();
    push_exp();
    @(negedge clock);
    idle(2);
    aclr = 1'b0;
    idle(NE + 1);
    for (int i = 0; i < NE; i++) rd(IB'(i));

    // Masked partial write merges with earlier contents.
    wr(4'd3, 8'hA5, 8'hFF);
    wr(4'd3, 8'h0F, 8'h0F);
    rd(4'd3);
    idle(1);

    // Same-edge read and write returns the post-write value, then holds it.
    wr(4'd5, 8'hF0, 8'hFF);
    step(1'b1, 4'd5, 1'b1, 4'd5, 8'h0F, 8'h0C, 1'b0);
    idle(3);
    rd(4'd5);

    // A write to the held address does not disturb q until the next read.
    wr(4'd2, 8'h11, 8'hFF);
    rd(4'd2);
    wr(4'd2, 8'h22, 8'hFF);
    idle(2);
    rd(4'd2);

    // Fill with ones, then flush. The flush and write in mid-sweep are ignored.
    for (int i = 0; i < NE; i++) wr(IB'(i), 8'hFF, 8'hFF);
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int k = 1; k <= NE + 1; k++) begin
      if (k == 8) step(1'b1, 4'd6, 1'b1, 4'd0, 8'hFF, 8'hAA, 1'b1);
      else        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    end
    for (int i = 0; i < NE; i++) rd(IB'(i));

    // A write on the flush edge lands, is visible to a colliding read, then gets swept.
    step(1'b1, 4'd4, 1'b1, 4'd4, 8'hFF, 8'h77, 1'b1);
    idle(NE + 1);
    rd(4'd4);

    // Reset in mid-sweep: q drops to zero at once, and the sweep restarts in full.
    wr(4'd9, 8'h5A, 8'hFF);
    rd(4'd9);
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    idle(7);
    async_reset(2);
    idle(NE + 1);
    rd(4'd9);

    // Random traffic, including the occasional flush.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), IB'($urandom_range(0, NE - 1)),
           1'($urandom_range(0, 1)), IB'($urandom_range(0, NE - 1)),
           DW'($urandom), DW'($urandom), 1'($urandom_range(0, 39) == 0));
    end
    idle(NE + 1);
    for (int i = 0; i < NE; i++) rd(IB'(i));
    idle(2);

    @(negedge clock);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
